// File: rtl/cursor_input.sv
// cursor_input: synchronises and debounces the cursor keys and put switch, tracks a wrapping
// board cursor and emits single-cycle move and put strobes.
module cursor_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit INIT = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic synced,
  output logic stable,
  output logic change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1;
  logic [CW-1:0] cnt;
  assign change = (synced != stable) && (cnt == LAST);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= INIT;
      synced <= INIT;
      stable <= INIT;
      cnt <= '0;
    end else begin
      s1 <= raw;
      synced <= s1;
      stable <= change ? synced : stable;
      cnt <= (synced == stable || change) ? '0 : cnt + 1'b1;
    end
  end
endmodule

module cursor_input #(
  parameter int BOARD_SIZE = 15,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_right_n,
  input  logic       key_down_n,
  input  logic       put_sw,
  input  logic       lock,
  output logic [7:0] coordi,
  output logic       put,
  output logic [7:0] put_coordi,
  output logic       move_evt
);
  localparam logic [3:0] LAST = 4'(BOARD_SIZE - 1);
  logic r_sync, r_stable, r_change;
  logic d_sync, d_stable, d_change;
  logic p_sync, p_stable, p_change;
  logic put_armed;
  logic [1:0] primed;
  logic [3:0] row, col;
  logic right_evt, down_evt, put_evt;
  cursor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_right (
    .clock(clock), .resetn(resetn), .raw(key_right_n),
    .synced(r_sync), .stable(r_stable), .change(r_change)
  );
  cursor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_down (
    .clock(clock), .resetn(resetn), .raw(key_down_n),
    .synced(d_sync), .stable(d_stable), .change(d_change)
  );
  cursor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_put (
    .clock(clock), .resetn(resetn), .raw(put_sw),
    .synced(p_sync), .stable(p_stable), .change(p_change)
  );
  assign right_evt = r_change && r_stable && !r_sync && !lock;
  assign down_evt = d_change && d_stable && !d_sync && !lock;
  assign put_evt = p_change && !p_stable && p_sync && put_armed && !lock;
  assign coordi = {row, col};
  // Arming waits until the synchroniser holds real samples, so a switch held high through reset
  // is never mistaken for a low level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      primed <= 2'b00;
      put_armed <= 1'b0;
      row <= 4'd0;
      col <= 4'd0;
      move_evt <= 1'b0;
      put <= 1'b0;
      put_coordi <= 8'h00;
    end else begin
      primed <= {primed[0], 1'b1};
      put_armed <= put_armed || (primed[1] && !p_stable && !p_sync);
      col <= right_evt ? ((col == LAST) ? 4'd0 : col + 4'd1) : col;
      row <= down_evt ? ((row == LAST) ? 4'd0 : row + 4'd1) : row;
      move_evt <= right_evt || down_evt;
      put <= put_evt;
      put_coordi <= put_evt ? {row, col} : put_coordi;
    end
  end
endmodule

// File: tb/tb_cursor_input.sv
// tb_cursor_input: directed checks of cursor movement, debounce, put arming and lock.
module tb_cursor_input;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic key_right_n = 1'b1;
  logic key_down_n = 1'b1;
  logic put_sw = 1'b0;
  logic lock = 1'b0;
  logic [7:0] coordi, put_coordi;
  logic put, move_evt;
  int checks = 0;
  int errors = 0;
  int moves = 0;
  int puts = 0;
  int dbl = 0;
  int m0, p0;
  logic prev_move = 1'b0;
  logic prev_put = 1'b0;

  cursor_input #(.BOARD_SIZE(15), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .resetn(resetn), .key_right_n(key_right_n), .key_down_n(key_down_n),
    .put_sw(put_sw), .lock(lock), .coordi(coordi), .put(put),
    .put_coordi(put_coordi), .move_evt(move_evt)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (move_evt) moves++;
    if (put) puts++;
    if ((move_evt && prev_move) || (put && prev_put)) dbl++;
    prev_move = move_evt;
    prev_put = put;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_right();
    key_right_n = 1'b0; tick(10);
    key_right_n = 1'b1; tick(10);
  endtask

  task automatic press_down();
    key_down_n = 1'b0; tick(10);
    key_down_n = 1'b1; tick(10);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (coordi !== 8'h00) begin errors++; $display("FAIL reset_coordi got %h exp 00", coordi); end
    checks++; if (put_coordi !== 8'h00) begin errors++; $display("FAIL reset_put_coordi got %h exp 00", put_coordi); end
    checks++; if (put !== 1'b0) begin errors++; $display("FAIL reset_put got %b exp 0", put); end
    checks++; if (move_evt !== 1'b0) begin errors++; $display("FAIL reset_move_evt got %b exp 0", move_evt); end
    resetn = 1'b1;
    tick(5);
  endtask

  task automatic test_right_wrap();
    m0 = moves;
    for (int i = 0; i < 14; i++) press_right();
    checks++; if (coordi !== 8'h0E) begin errors++; $display("FAIL right14_coordi got %h exp 0e", coordi); end
    checks++; if (moves - m0 !== 14) begin errors++; $display("FAIL right14_moves got %0d exp 14", moves - m0); end
    press_right();
    checks++; if (coordi !== 8'h00) begin errors++; $display("FAIL right_wrap_coordi got %h exp 00", coordi); end
    checks++; if (moves - m0 !== 15) begin errors++; $display("FAIL right_wrap_moves got %0d exp 15", moves - m0); end
  endtask

  task automatic test_debounce();
    m0 = moves;
    key_down_n = 1'b0; tick(3);
    key_down_n = 1'b1; tick(15);
    checks++; if (coordi !== 8'h00) begin errors++; $display("FAIL glitch_coordi got %h exp 00", coordi); end
    checks++; if (moves - m0 !== 0) begin errors++; $display("FAIL glitch_moves got %0d exp 0", moves - m0); end
    key_down_n = 1'b0; tick(6);
    key_down_n = 1'b1; tick(15);
    checks++; if (coordi !== 8'h10) begin errors++; $display("FAIL down_coordi got %h exp 10", coordi); end
    checks++; if (moves - m0 !== 1) begin errors++; $display("FAIL down_moves got %0d exp 1", moves - m0); end
  endtask

  task automatic test_put();
    press_down(); press_down();
    for (int i = 0; i < 5; i++) press_right();
    checks++; if (coordi !== 8'h35) begin errors++; $display("FAIL pos35_coordi got %h exp 35", coordi); end
    p0 = puts;
    put_sw = 1'b1; tick(20);
    checks++; if (puts - p0 !== 1) begin errors++; $display("FAIL put_count got %0d exp 1", puts - p0); end
    checks++; if (put_coordi !== 8'h35) begin errors++; $display("FAIL put_coordi got %h exp 35", put_coordi); end
    put_sw = 1'b0; tick(20);
    checks++; if (put_coordi !== 8'h35) begin errors++; $display("FAIL put_coordi_hold got %h exp 35", put_coordi); end
    checks++; if (puts - p0 !== 1) begin errors++; $display("FAIL put_lower_count got %0d exp 1", puts - p0); end
  endtask

  task automatic test_put_through_reset();
    put_sw = 1'b1;
    resetn = 1'b0; tick(3);
    checks++; if (coordi !== 8'h00) begin errors++; $display("FAIL rst2_coordi got %h exp 00", coordi); end
    p0 = puts;
    resetn = 1'b1; tick(20);
    checks++; if (puts - p0 !== 0) begin errors++; $display("FAIL held_put_count got %0d exp 0", puts - p0); end
    put_sw = 1'b0; tick(20);
    put_sw = 1'b1; tick(20);
    checks++; if (puts - p0 !== 1) begin errors++; $display("FAIL rearm_put_count got %0d exp 1", puts - p0); end
    checks++; if (put_coordi !== 8'h00) begin errors++; $display("FAIL rearm_put_coordi got %h exp 00", put_coordi); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 14; i++) press_right();
    checks++; if (coordi !== 8'h0E) begin errors++; $display("FAIL pre_sim_coordi got %h exp 0e", coordi); end
    m0 = moves;
    key_right_n = 1'b0; key_down_n = 1'b0; tick(10);
    key_right_n = 1'b1; key_down_n = 1'b1; tick(10);
    checks++; if (coordi !== 8'h10) begin errors++; $display("FAIL sim_coordi got %h exp 10", coordi); end
    checks++; if (moves - m0 !== 1) begin errors++; $display("FAIL sim_moves got %0d exp 1", moves - m0); end
  endtask

  task automatic test_lock();
    m0 = moves; p0 = puts;
    lock = 1'b1;
    press_right();
    put_sw = 1'b0; tick(20);
    put_sw = 1'b1; tick(20);
    checks++; if (coordi !== 8'h10) begin errors++; $display("FAIL lock_coordi got %h exp 10", coordi); end
    checks++; if (puts - p0 !== 0) begin errors++; $display("FAIL lock_puts got %0d exp 0", puts - p0); end
    checks++; if (moves - m0 !== 0) begin errors++; $display("FAIL lock_moves got %0d exp 0", moves - m0); end
    lock = 1'b0; tick(20);
    checks++; if (coordi !== 8'h10) begin errors++; $display("FAIL unlock_coordi got %h exp 10", coordi); end
    checks++; if (puts - p0 !== 0) begin errors++; $display("FAIL unlock_puts got %0d exp 0", puts - p0); end
    press_right();
    checks++; if (coordi !== 8'h11) begin errors++; $display("FAIL after_lock_coordi got %h exp 11", coordi); end
    checks++; if (moves - m0 !== 1) begin errors++; $display("FAIL after_lock_moves got %0d exp 1", moves - m0); end
    checks++; if (put_coordi !== 8'h00) begin errors++; $display("FAIL lock_put_coordi got %h exp 00", put_coordi); end
  endtask

  initial begin
    test_reset();
    test_right_wrap();
    test_debounce();
    test_put();
    test_put_through_reset();
    test_simultaneous();
    test_lock();
    checks++; if (dbl !== 0) begin errors++; $display("FAIL strobe_width got %0d multi-cycle strobes exp 0", dbl); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cursor_input.md
Name: cursor_input

Overview:
- Input-conditioning stage directly upstream of the GoBang control/datapath pair.
- Synchronises and debounces the move-right key, move-down key and put switch, and maintains the cursor position (row, column) with wrap-around.
- Emits an 8-bit coordinate bus and a single-cycle put strobe carrying the coordinate captured at that instant.
- Replaces raw SW-based coordinate entry at the top level.

Parameters:
- BOARD_SIZE, 15: cells per row/column. Legal range 2..16. Coordinates run 0..BOARD_SIZE-1.
- DEBOUNCE_CYCLES, 500000: consecutive clock cycles a raw input must hold a new level before it is accepted. 10 ms at 50 MHz. Legal range 1..2^20.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- key_right_n  in  1  raw push button, active-low; a press moves the cursor one column right
- key_down_n  in  1  raw push button, active-low; a press moves the cursor one row down
- put_sw  in  1  raw put switch, active-high
- lock  in  1  game-over/freeze. While high, moves and puts are ignored but debouncing continues.
- coordi  out  8  live cursor: [7:4] row, [3:0] column
- put  out  1  single-cycle put strobe
- put_coordi  out  8  coordinate captured with put; held until the next put
- move_evt  out  1  single-cycle pulse whenever the cursor changes

Behaviour:
- Reset (asynchronous, resetn low), all registers cleared immediately:
  - row=0, col=0, coordi=8'h00, put_coordi=8'h00, put=0, move_evt=0
  - debounced key states=1 (released), debounced put state=0
  - debounce counters=0, put_armed=0
- Synchronisation: each raw input passes through a 2-flop synchroniser. Synchroniser reset values are 1 for the keys and 0 for the put switch.
- Debounce: one counter per input, width ceil(log2(DEBOUNCE_CYCLES+1)).
  - If synced == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced value in the same cycle and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is never accepted.
- Events:
  - Key press event = stable key transitions 1->0. Release generates nothing.
  - Put event = stable put transitions 0->1 while put_armed=1.
  - put_armed sets when stable put is 0. A switch left high through reset therefore never fires until it has been lowered and raised again.
- Cursor update (registered; coordi changes the cycle after the event):
  - Right event: col = (col==BOARD_SIZE-1) ? 0 : col+1.
  - Down event: row = (row==BOARD_SIZE-1) ? 0 : row+1.
  - Simultaneous right and down events both apply in the same cycle.
  - move_evt=1 for exactly that one cycle.
  - Row and column widths are 4 bits. Unused upper values are unreachable. Any BOARD_SIZE<16 wraps correctly.
- Put (registered, latency 1 cycle after the stable put edge):
  - put=1 for exactly one cycle. put_coordi = the coordi value present in the event cycle.
  - Put simultaneous with a move: put_coordi carries the pre-move coordinate, and the move still applies.
- lock=1: right, down and put events are discarded, not queued. Debounced state and put_armed still track the inputs. Lowering lock does not replay missed events.
- Holding a key produces one move only (no auto-repeat).
- Reset mid-debounce abandons the pending transition. A put strobe can never straddle reset: put clears asynchronously.

Test Plan (bench uses DEBOUNCE_CYCLES=4, BOARD_SIZE=15):
- Reset, then 14 clean key_right_n presses (each low 10 cycles, high 10 cycles) -> coordi 8'h0E and 14 move_evt pulses. A 15th press -> coordi 8'h00 (wrap).
- key_down_n low for 3 cycles then high -> no move, coordi unchanged. Low for 6 cycles -> row +1 exactly once, move_evt high for one cycle.
- Cursor at row 3, col 5; raise put_sw and hold 20 cycles -> exactly one put pulse with put_coordi=8'h35. put_coordi holds 8'h35 after put_sw is lowered.
- put_sw high before resetn deasserts -> no put pulse. Lower put_sw, then raise it again -> one put pulse.
- key_right_n and key_down_n pressed on the same cycle from coordi 8'h0E -> coordi 8'h10 (col wraps, row increments) with a single move_evt.
- lock=1 while pressing right and toggling put -> coordi unchanged and no put. Release lock -> no delayed events. The next press then acts normally.
